// File: rtl/bsr_pkg.sv
// Shared definitions for the bidirectional shift register and its loader.
// Holds the loader FSM state encoding and the shift-direction constants
// used by bsr, bsr_loader and their benches.
package bsr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // 0: m enters bit 0 (left shift), 1: m enters bit N-1 (right shift)
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/bsr_loader.sv
// bsr_loader: accepts an N-bit word plus direction over valid/ready and
// serializes it into a bsr as N enabled shifts, each preceded by GAP idle
// cycles, so the register ends up holding the accepted word.
// Ports:
//   clk, rst      clock (rising edge), async active-low reset
//   din, dir_in   word and direction, captured on valid & ready
//   valid, ready  input handshake
//   m, dir, en    serial bit, direction and shift enable to bsr
//   busy          transfer in progress
//   done          one-cycle pulse after the last shift
module bsr_loader
  import bsr_pkg::*;
#(
  parameter int N   = 4,
  parameter int GAP = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic         dir_in,
  input  logic         valid,
  output logic         ready,
  output logic         m,
  output logic         dir,
  output logic         en,
  output logic         busy,
  output logic         done
);

  localparam int BW = (N > 1) ? $clog2(N) : 1;

  state_t        state, state_nxt;
  logic [N-1:0]  word;
  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] nxt_cnt;
  logic [BW-1:0] nxt_idx;
  logic          accept;
  logic          last_bit;
  logic          gap_last;

  // Moore decode straight off the state register
  assign ready  = (state == IDLE) || (state == DONE);
  assign busy   = (state == SETUP) || (state == SHIFT);
  assign en     = (state == SHIFT);
  assign done   = (state == DONE);

  assign accept   = valid && ready;
  assign last_bit = (bit_cnt == BW'(N - 1));
  assign nxt_cnt  = bit_cnt + BW'(1);
  // Right shifts go LSB first, left shifts MSB first, so both directions
  // leave the register equal to the word.
  assign nxt_idx  = (dir == DIR_RIGHT) ? nxt_cnt : BW'(N - 1) - nxt_cnt;

  generate
    if (GAP > 0) begin : g_gap
      localparam int GW = $clog2(GAP + 1);
      logic [GW-1:0] gap_cnt;

      // Counts the SETUP cycles of the current slot; cleared outside SETUP
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                gap_cnt <= '0;
        else if (state == SETUP) gap_cnt <= gap_cnt + GW'(1);
        else                     gap_cnt <= '0;
      end

      assign gap_last = (gap_cnt == GW'(GAP - 1));
    end else begin : g_nogap
      assign gap_last = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = (GAP > 0) ? SETUP : SHIFT;
        else        state_nxt = IDLE;
      end
      SETUP:   if (gap_last) state_nxt = SHIFT;
      SHIFT: begin
        if (last_bit)     state_nxt = DONE;
        else if (GAP > 0) state_nxt = SETUP;
        else              state_nxt = SHIFT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Captured word, bit pointer and the registered serial outputs. m and
  // dir are only updated on accept or when leaving a shift slot, so they
  // hold through SETUP, SHIFT and after completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word    <= '0;
      bit_cnt <= '0;
      m       <= 1'b0;
      dir     <= DIR_LEFT;
    end else if (accept) begin
      word    <= din;
      dir     <= dir_in;
      bit_cnt <= '0;
      m       <= (dir_in == DIR_RIGHT) ? din[0] : din[N-1];
    end else if (state == SHIFT && !last_bit) begin
      bit_cnt <= nxt_cnt;
      m       <= word[nxt_idx];
    end
  end

endmodule

// File: tb/tb_bsr_loader.sv
// Scoreboard bench for bsr_loader: one instance with GAP=0 and one with
// GAP=2. Stimulus pushes hand-computed shift/done events; monitors pop
// them when the DUT raises en or done, and a behavioral bsr checks the
// assembled word at done.
module tb_bsr_loader;
  import bsr_pkg::*;

  typedef struct {
    bit         is_done;
    bit         m;
    bit         d;
    int         cyc;
    logic [3:0] w;
  } exp_t;

  logic clk, rst;
  logic [3:0] din0, din2;
  logic dir_in0, dir_in2, valid0, valid2;
  logic ready0, m0, dir0, en0, busy0, done0;
  logic ready2, m2, dir2, en2, busy2, done2;
  logic [3:0] out0, out2;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q2[$];
  exp_t e0, e2;

  bsr_loader #(.N(4), .GAP(0)) u0 (
    .clk(clk), .rst(rst), .din(din0), .dir_in(dir_in0), .valid(valid0),
    .ready(ready0), .m(m0), .dir(dir0), .en(en0), .busy(busy0), .done(done0)
  );

  bsr_loader #(.N(4), .GAP(2)) u2 (
    .clk(clk), .rst(rst), .din(din2), .dir_in(dir_in2), .valid(valid2),
    .ready(ready2), .m(m2), .dir(dir2), .en(en2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioral downstream bsr registers
  always @(posedge clk) begin
    if (en0) out0 <= (dir0 == DIR_RIGHT) ? {m0, out0[3:1]} : {out0[2:0], m0};
    if (en2) out2 <= (dir2 == DIR_RIGHT) ? {m2, out2[3:1]} : {out2[2:0], m2};
  end

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (en0 || done0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL u0 unexpected en=%0b done=%0b cyc=%0d", en0, done0, cyc);
        end else begin
          e0 = q0.pop_front();
          if (en0)
            chk("u0 shift", 64'({e0.is_done, m0, dir0, busy0, ready0, 32'(cyc)}),
                64'({1'b0, e0.m, e0.d, 1'b1, 1'b0, 32'(e0.cyc)}));
          else
            chk("u0 done", 64'({e0.is_done, ready0, busy0, out0, 32'(cyc)}),
                64'({1'b1, 1'b1, 1'b0, e0.w, 32'(e0.cyc)}));
        end
      end else if (busy0 && q0.size() > 0 && !q0[0].is_done) begin
        chk("u0 hold", 64'({m0, dir0, ready0}), 64'({q0[0].m, q0[0].d, 1'b0}));
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (en2 || done2) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL u2 unexpected en=%0b done=%0b cyc=%0d", en2, done2, cyc);
        end else begin
          e2 = q2.pop_front();
          if (en2)
            chk("u2 shift", 64'({e2.is_done, m2, dir2, busy2, ready2, 32'(cyc)}),
                64'({1'b0, e2.m, e2.d, 1'b1, 1'b0, 32'(e2.cyc)}));
          else
            chk("u2 done", 64'({e2.is_done, ready2, busy2, out2, 32'(cyc)}),
                64'({1'b1, 1'b1, 1'b0, e2.w, 32'(e2.cyc)}));
        end
      end else if (busy2 && q2.size() > 0 && !q2[0].is_done) begin
        chk("u2 hold", 64'({m2, dir2, ready2}), 64'({q2[0].m, q2[0].d, 1'b0}));
      end
    end
  end

  // Offer a word to instance u (0 or 2). ms lists the expected m sequence
  // first bit in ms[3]; s is the slot length GAP+1. k returns the cycle
  // whose closing edge accepted the word.
  task automatic send(input int u, input logic [3:0] w, input logic d,
                      input logic [3:0] ms, input int s, input bit hold,
                      output int k);
    bit   got;
    exp_t e;
    got = 1'b0;
    k   = -1;
    @(negedge clk);
    if (u == 0) begin din0 = w; dir_in0 = d; valid0 = 1'b1; end
    else        begin din2 = w; dir_in2 = d; valid2 = 1'b1; end
    for (int t = 0; t < 60 && !got; t++) begin
      if ((u == 0) ? ready0 : ready2) begin
        got = 1'b1;
        k   = cyc;
        for (int i = 0; i < 4; i++) begin
          e.is_done = 1'b0; e.m = ms[3-i]; e.d = d; e.cyc = k + (i + 1) * s; e.w = w;
          if (u == 0) q0.push_back(e); else q2.push_back(e);
        end
        e.is_done = 1'b1; e.m = 1'b0; e.cyc = k + 4 * s + 1;
        if (u == 0) q0.push_back(e); else q2.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) begin
          if (u == 0) valid0 = 1'b0; else valid2 = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL u%0d accept timeout word=%b", u, w);
      if (u == 0) valid0 = 1'b0; else valid2 = 1'b0;
    end
  endtask

  initial begin
    int k1, k2;
    rst = 1'b1;
    din0 = '0; din2 = '0; dir_in0 = 1'b0; dir_in2 = 1'b0;
    valid0 = 1'b0; valid2 = 1'b0;
    #3 rst = 1'b0;

    // Reset held with random traffic
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("reset u0", 64'({ready0, m0, dir0, en0, busy0, done0}), 64'(6'b100000));
      chk("reset u2", 64'({ready2, m2, dir2, en2, busy2, done2}), 64'(6'b100000));
      valid0 = 1'($urandom); valid2 = 1'($urandom);
      din0 = 4'($urandom); din2 = 4'($urandom);
      dir_in0 = 1'($urandom); dir_in2 = 1'($urandom);
    end
    @(negedge clk);
    valid0 = 1'b0; valid2 = 1'b0;
    rst = 1'b1;

    // Right and left transfers of 1011
    send(0, 4'b1011, 1'b1, 4'b1101, 1, 1'b0, k1);
    send(0, 4'b1011, 1'b0, 4'b1011, 1, 1'b0, k1);

    // valid held through busy: 0110 accepted on the DONE edge
    send(0, 4'b1011, 1'b1, 4'b1101, 1, 1'b1, k1);
    send(0, 4'b0110, 1'b1, 4'b0110, 1, 1'b0, k2);
    chk("b2b accept cycle", 64'(k2), 64'(k1 + 5));

    // Reset after the 2nd enabled shift
    send(0, 4'b1011, 1'b1, 4'b1101, 1, 1'b0, k1);
    while (cyc < k1 + 2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    q0.delete();
    #1;
    chk("mid reset u0", 64'({ready0, m0, dir0, en0, busy0, done0}), 64'(6'b100000));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    send(0, 4'b0101, 1'b1, 4'b1010, 1, 1'b0, k1);

    // GAP=2 instance
    send(2, 4'b1001, 1'b1, 4'b1001, 3, 1'b0, k1);

    for (int t = 0; t < 200; t++) begin
      if (q0.size() == 0 && q2.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 64'(q0.size() + q2.size()), 64'(0));
    repeat (3) @(negedge clk);
    chk("idle after u0", 64'({ready0, en0, busy0, done0}), 64'(4'b1000));
    chk("idle after u2", 64'({ready2, en2, busy2, done2, out2}), 64'({4'b1000, 4'b1001}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsr_loader.md
# bsr_loader

Upstream feeder for the bidirectional shift register (`bsr`). Accepts an N-bit parallel word and a shift direction over a valid/ready handshake, then drives the register's serial input `m`, `dir` and `en` for exactly N enabled shifts. After these shifts the register's parallel output equals the accepted word. It pulses `done` when the transfer completes.

## Interface
- `N`, 4: word width; must match the downstream `bsr`.
- `GAP`, 0: idle cycles inserted before each enabled shift (`en`=0, `m` held); ≥0.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `din`  in  N  word to load.
- `dir_in`  in  1  requested direction: 1 = right shift (`m` enters bit N-1), 0 = left shift (`m` enters bit 0).
- `valid`  in  1  `din`/`dir_in` valid.
- `ready`  out  1  loader can accept a word.
- `m`  out  1  serial bit to `bsr`.
- `dir`  out  1  direction to `bsr`.
- `en`  out  1  shift enable to `bsr`.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse, transfer complete.

## Operation
- Handshake: a word is accepted on a rising edge with `valid`=1 and `ready`=1. `din` and `dir_in` are captured at that edge. Later changes are ignored until the next acceptance.
- Bit order:
  - `dir_in`=1: LSB first, din[0]..din[N-1].
  - `dir_in`=0: MSB first, din[N-1]..din[0].
  - Either order leaves `bsr` out == din after N shifts.
- FSM (all outputs registered, Moore):
  - IDLE: `ready`=1, `busy`=0. On accept, go to SETUP if GAP>0, else SHIFT.
  - SETUP: `en`=0, `m`/`dir` hold the current bit. Stay GAP cycles, then go to SHIFT.
  - SHIFT: `en`=1 for one cycle. If this is the last bit, go to DONE. Otherwise advance to the next bit and go to SETUP (GAP>0) or SHIFT (GAP=0).
  - DONE: `done`=1, `ready`=1, `busy`=0, `en`=0. On accept, go to SETUP/SHIFT; otherwise go to IDLE.
- `busy`=1 in SETUP and SHIFT only. `ready`=0 whenever `busy`=1.
- `valid` while `busy` is ignored; no queueing.
- Counters:
  - Bit counter: $clog2(N) bits, counts 0..N-1, no wrap past N-1.
  - Gap counter: $clog2(GAP+1) bits. It is absent when GAP=0.
- After DONE/IDLE, `m` and `dir` hold their last values and `en` stays 0.
- Reset at any time, including mid-transfer:
  - State goes to IDLE immediately.
  - Outputs: `m`=0, `dir`=0, `en`=0, `busy`=0, `done`=0, `ready`=1.
  - The partial word is discarded. The next word starts at bit 0.

## Timing
- Accept at edge k.
- Bit i (i=0..N-1) appears on `m` from cycle k+1+i(GAP+1). Its `en` cycle is k+(i+1)(GAP+1).
- `m` and `dir` are stable for the whole slot, including the `en` cycle.
- `done` is high in cycle k+N(GAP+1)+1.
- Back-to-back: with `valid` held high, the next accept happens at the DONE cycle edge. Throughput is one word per N(GAP+1)+1 cycles.
- Latency from accept to first `en`: GAP+1 cycles.

## Structure
- Shared package `bsr_pkg` holds:
  - FSM state encoding: IDLE, SETUP, SHIFT, DONE.
  - Direction constants DIR_LEFT=0 and DIR_RIGHT=1, also used by `bsr` and its bench.
- No sub-module. The FSM, bit counter and gap counter live inline. The shift-out data register is the captured word, indexed by the bit counter and direction.

## Test plan
- Reset: hold `rst`=0 with random `valid`/`din` → `m`=0, `dir`=0, `en`=0, `busy`=0, `done`=0, `ready`=1 throughout.
- N=4, GAP=0, `din`=1011, `dir_in`=1, accept at k:
  - `m`=1,1,0,1 with `en`=1 in cycles k+1..k+4 and `dir`=1.
  - `done` at k+5.
  - Attached `bsr` out = 1011.
- Same word with `dir_in`=0: `m`=1,0,1,1, `dir`=0, `bsr` out = 1011, `done` at k+5.
- `valid` held with `din`=0110 during busy:
  - The busy word is ignored.
  - The next accept occurs at the DONE edge (k+5).
  - `en` resumes at k+6 and `bsr` ends at 0110.
- Mid-transfer reset: assert `rst`=0 after the 2nd `en` of 1011.
  - All outputs go to reset values without waiting for a clock edge.
  - A subsequent 0101 (`dir_in`=1) produces `m`=1,0,1,0 starting from bit 0.
- GAP=2, `din`=1001, `dir_in`=1:
  - `en` pulses at k+3, k+6, k+9, k+12.
  - `m` is stable across each 3-cycle slot.
  - `done` at k+13.
